// File: rtl/mbus_wire_ctrl_mc.sv
// mbus_wire_ctrl_mc: registered successor wire controller at the MBus DOUT/CLKOUT pins.
// Chooses between isolation pass-through (DIN/CLKIN) and bus-core drive, hands over
// to the bus core only after the ring has been idle for IDLE_CYC cycles, and services
// queued external interrupts by holding DOUT low for INT_HOLD_CYC cycles each.
// Optional build macro: MBUS_WIRE_INT_SYNC_EN puts a 2-flop synchronizer on EXT_INT.

`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif

module mbus_wire_ctrl_mc #(
  parameter int NUM_INT      = 4,
  parameter int INT_HOLD_CYC = 8,
  parameter int IDLE_CYC     = 4,
  localparam int IDW = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               DOUT_FROM_BUS,
  input  logic               CLKOUT_FROM_BUS,
  input  logic               DIN,
  input  logic               CLKIN,
  input  logic               RELEASE_ISO_FROM_SLEEP_CTRL,
  input  logic [NUM_INT-1:0] EXT_INT,
  output logic               DOUT,
  output logic               CLKOUT,
  output logic [NUM_INT-1:0] INT_PENDING,
  output logic               INT_ACK,
  output logic [IDW-1:0]     INT_ID,
  output logic               DRIVE_ACTIVE
);

  localparam int ICW = $clog2(IDLE_CYC + 1);
  localparam int HCW = $clog2(INT_HOLD_CYC + 1);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CYC);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(INT_HOLD_CYC - 1);

  typedef enum logic [1:0] {ST_FWD, ST_WAIT_IDLE, ST_DRIVE, ST_INT} state_t;

  state_t             state;
  logic [ICW-1:0]     idle_cnt;
  logic [HCW-1:0]     hold_cnt;
  logic [NUM_INT-1:0] ext_hist;
  logic [NUM_INT-1:0] ext_int_s;

  logic               iso_hold;
  logic               any_pend;
  logic               hold_done;
  logic [NUM_INT-1:0] int_rise;
  logic [NUM_INT-1:0] int_clr;
  logic [NUM_INT-1:0] pending_nxt;
  logic [ICW-1:0]     idle_inc;
  logic [IDW-1:0]     lowest_id;

`ifdef MBUS_WIRE_INT_SYNC_EN
  logic [NUM_INT-1:0] sync_q1;
  logic [NUM_INT-1:0] sync_q2;

  // Two-stage synchronizer for asynchronous interrupt requests
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      sync_q1 <= EXT_INT;
      sync_q2 <= EXT_INT;
    end else begin
      sync_q1 <= EXT_INT;
      sync_q2 <= sync_q1;
    end
  end

  assign ext_int_s = sync_q2;
`else
  // Caller guarantees EXT_INT is already CLK-synchronous
  assign ext_int_s = EXT_INT;
`endif

  // Lowest-index pending request; lower index has higher priority
  function automatic logic [IDW-1:0] lowest_set(input logic [NUM_INT-1:0] pend);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pend[i]) r = IDW'(i);
    end
    return r;
  endfunction

  // Pending-queue update, window completion and counter increments
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    int_clr   = '0;
    iso_hold  = (RELEASE_ISO_FROM_SLEEP_CTRL == `IO_HOLD);
    any_pend  = |INT_PENDING;
    hold_done = (state == ST_INT) && !iso_hold && (hold_cnt == HOLD_LAST);
    if (hold_done) int_clr[INT_ID] = 1'b1;
    int_rise    = ext_int_s & ~ext_hist;
    // A fresh edge on the bit being cleared keeps it pending
    pending_nxt = (INT_PENDING & ~int_clr) | int_rise;
    idle_inc    = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
    lowest_id   = lowest_set(INT_PENDING);
  end

  // Wire-control FSM with registered pin outputs
  always_ff @(posedge CLK) begin
    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    if (!RESETn) begin
      state        <= ST_FWD;
      DOUT         <= 1'b1;
      CLKOUT       <= 1'b1;
      INT_PENDING  <= '0;
      INT_ACK      <= 1'b0;
      INT_ID       <= '0;
      DRIVE_ACTIVE <= 1'b0;
      idle_cnt     <= '0;
      hold_cnt     <= '0;
      // Seed history with the live input so a held-high request is not an edge on release
      ext_hist     <= EXT_INT;
    end else begin
      ext_hist    <= ext_int_s;
      INT_PENDING <= pending_nxt;
      INT_ACK     <= 1'b0;
      case (state)
        ST_FWD: begin
          DOUT   <= any_pend ? 1'b0 : DIN;
          CLKOUT <= CLKIN;
          if (!iso_hold) begin
            state    <= ST_WAIT_IDLE;
            idle_cnt <= '0;
          end
        end
        ST_WAIT_IDLE: begin
          DOUT   <= any_pend ? 1'b0 : DIN;
          CLKOUT <= CLKIN;
          if (iso_hold) begin
            state <= ST_FWD;
          end else if (DIN && CLKIN) begin
            idle_cnt <= idle_inc;
            if (idle_inc == IDLE_MAX) begin
              state        <= ST_DRIVE;
              DRIVE_ACTIVE <= 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        ST_DRIVE: begin
          DOUT   <= DOUT_FROM_BUS;
          CLKOUT <= CLKOUT_FROM_BUS;
          if (iso_hold) begin
            state        <= ST_FWD;
            DRIVE_ACTIVE <= 1'b0;
          end else if (any_pend && DOUT_FROM_BUS && CLKOUT_FROM_BUS) begin
            state    <= ST_INT;
            INT_ID   <= lowest_id;
            hold_cnt <= '0;
          end
        end
        ST_INT: begin
          DOUT   <= 1'b0;
          CLKOUT <= CLKOUT_FROM_BUS;
          if (iso_hold) begin
            // Abandoned window: request stays queued and restarts from zero later
            state        <= ST_FWD;
            DRIVE_ACTIVE <= 1'b0;
            hold_cnt     <= '0;
          end else if (hold_done) begin
            state   <= ST_DRIVE;
            INT_ACK <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state        <= ST_FWD;
          DRIVE_ACTIVE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_wire_ctrl_mc.sv
// tb_mbus_wire_ctrl_mc: directed scoreboard bench for mbus_wire_ctrl_mc (default build).

`ifndef IO_HOLD
`define IO_HOLD 1'b1
`endif

module tb_mbus_wire_ctrl_mc;

  logic       clk = 1'b0;
  logic       resetn;
  logic       dfb, cfb, din, clkin, iso;
  logic [3:0] ext;
  logic       dout, clkout, int_ack, drive_active;
  logic [3:0] int_pending;
  logic [1:0] int_id;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic       dout;
    logic       clkout;
    logic [3:0] pend;
    logic       ack;
    logic [1:0] id;
    logic       drv;
  } exp_t;

  exp_t sb[$];

  mbus_wire_ctrl_mc #(.NUM_INT(4), .INT_HOLD_CYC(8), .IDLE_CYC(4)) dut (
    .CLK                         (clk),
    .RESETn                      (resetn),
    .DOUT_FROM_BUS               (dfb),
    .CLKOUT_FROM_BUS             (cfb),
    .DIN                         (din),
    .CLKIN                       (clkin),
    .RELEASE_ISO_FROM_SLEEP_CTRL (iso),
    .EXT_INT                     (ext),
    .DOUT                        (dout),
    .CLKOUT                      (clkout),
    .INT_PENDING                 (int_pending),
    .INT_ACK                     (int_ack),
    .INT_ID                      (int_id),
    .DRIVE_ACTIVE                (drive_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push the expectation for this edge, clock once, then pop and compare
  task automatic tick(input string tag, input logic e_dout, input logic e_clk,
                      input logic [3:0] e_pend, input logic e_ack,
                      input logic [1:0] e_id, input logic e_drv);
    exp_t e;
    e.tag = tag; e.dout = e_dout; e.clkout = e_clk; e.pend = e_pend;
    e.ack = e_ack; e.id = e_id; e.drv = e_drv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".dout"},   {7'd0, dout},         {7'd0, e.dout});
    check({e.tag, ".clkout"}, {7'd0, clkout},       {7'd0, e.clkout});
    check({e.tag, ".pend"},   {4'd0, int_pending},  {4'd0, e.pend});
    check({e.tag, ".ack"},    {7'd0, int_ack},      {7'd0, e.ack});
    check({e.tag, ".id"},     {6'd0, int_id},       {6'd0, e.id});
    check({e.tag, ".drv"},    {7'd0, drive_active}, {7'd0, e.drv});
  endtask

  // One full 8-cycle low window; CLKOUT follows the bus clock, which toggles here
  task automatic window(input string tag, input logic [1:0] id,
                        input logic [3:0] pend_during, input logic [3:0] pend_after,
                        input logic [3:0] ext_last);
    for (int j = 0; j < 8; j++) begin
      cfb = (j % 2 == 0);
      if (j == 7) ext = ext_last;
      tick(tag, 1'b0, cfb, (j == 7) ? pend_after : pend_during, (j == 7), id, 1'b1);
    end
    cfb = 1'b1;
  endtask

  initial begin
    // 1: reset with random inputs
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {dfb, cfb, din, clkin, iso} = 5'($urandom);
      ext = 4'($urandom);
      tick("reset", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    end
    resetn = 1'b1;
    iso = `IO_HOLD;
    ext = 4'b0000;
    dfb = 1'b1; cfb = 1'b1;

    // 2: isolation pass-through with one-cycle latency
    for (int i = 0; i < 6; i++) begin
      din = i[0]; clkin = i[1];
      tick("fwd_pass", din, clkin, 4'b0000, 1'b0, 2'd0, 1'b0);
    end

    // 2: release, glitch on the 2nd idle cycle restarts the idle count
    din = 1'b1; clkin = 1'b1; iso = ~`IO_HOLD;
    tick("release", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    tick("idle1",   1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    din = 1'b0;
    tick("glitch",  1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    din = 1'b1;
    for (int i = 1; i <= 4; i++)
      tick("idle_after_glitch", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, (i == 4));

    // DRIVE follows the bus core sources
    dfb = 1'b0; cfb = 1'b1;
    tick("drive_d0", 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);
    dfb = 1'b1; cfb = 1'b0;
    tick("drive_c0", 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    cfb = 1'b1;
    tick("drive_11", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1);

    // 3: single interrupt on bit 2
    ext = 4'b0100;
    tick("int2_pend",  1'b1, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b1);
    tick("int2_entry", 1'b1, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1);
    window("int2_win", 2'd2, 4'b0100, 4'b0000, 4'b0100);
    ext = 4'b0000;
    tick("int2_after", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1);

    // 4: simultaneous requests on bits 1 and 3, serviced lowest first
    ext = 4'b1010;
    tick("dual_pend",  1'b1, 1'b1, 4'b1010, 1'b0, 2'd2, 1'b1);
    tick("dual_entry1", 1'b1, 1'b1, 4'b1010, 1'b0, 2'd1, 1'b1);
    window("dual_win1", 2'd1, 4'b1010, 4'b1000, 4'b1010);
    tick("dual_gap",   1'b1, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1);
    window("dual_win3", 2'd3, 4'b1000, 4'b0000, 4'b1010);
    tick("dual_after", 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1);

    // 5: pending bit 0 while the bus is busy stays in DRIVE
    ext = 4'b1011; dfb = 1'b0; cfb = 1'b1;
    tick("busy_pend", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1);
    tick("busy_hold", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1);
    tick("busy_hold", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1);
    dfb = 1'b1; cfb = 1'b0;
    tick("busy_c0",   1'b1, 1'b0, 4'b0001, 1'b0, 2'd3, 1'b1);
    cfb = 1'b1;
    tick("busy_entry", 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);

    // 6: isolation asserted on INT cycle 3 aborts the window
    tick("abort_c1", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);
    tick("abort_c2", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);
    iso = `IO_HOLD;
    tick("abort_c3", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    din = 1'b1; clkin = 1'b1;
    tick("abort_wake", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    clkin = 1'b0;
    tick("abort_wake_c0", 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);

    // 6: re-release with idle ring, full window; a new edge on the clear cycle keeps the bit
    clkin = 1'b1; iso = ~`IO_HOLD;
    tick("rerelease", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
    for (int i = 1; i <= 4; i++)
      tick("reidle", 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0, (i == 4));
    ext = 4'b1010;
    tick("reentry", 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);
    window("re_win", 2'd0, 4'b0001, 4'b0001, 4'b1011);
    tick("set_wins_reentry", 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
